count_cmp_irq: RTL and testbench
================================

COUNT_CMP_IRQ -- requirements
Module: count_cmp_irq

Interface
REQ-001 SHALL have parameter BITS, default 32, meaning width of the consumed count value and the compare/period/capture registers.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning number of capture FIFO entries (power of two, 2..16).
REQ-003 SHALL have port wb_clk_i, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port wb_rst_ni, input, 1, synchronous active-low reset.
REQ-005 SHALL have port count, input, BITS, free-running value from the upstream counter stage.
REQ-006 SHALL have ports wbs_stb_i, wbs_cyc_i, wbs_we_i (input, 1), wbs_sel_i (input, 4), wbs_adr_i and wbs_dat_i (input, 32), the Wishbone slave request.
REQ-007 SHALL have ports wbs_ack_o (output, 1) and wbs_dat_o (output, 32), the Wishbone slave response.
REQ-008 SHALL have port irq, output, 1, level interrupt to the management SoC.

Function
REQ-009 SHALL decode wbs_adr_i[4:2] only: 0 CTRL, 1 CMP, 2 PERIOD, 3 STATUS, 4 CAPTURE; other offsets read 0, writes ignored, still acked.
REQ-010 SHALL take a request when stb&cyc&!ack, assert wbs_ack_o for exactly one cycle on the next edge, with wbs_dat_o registered in that cycle; back-to-back requests complete every second cycle.
REQ-011 SHALL apply CTRL/CMP/PERIOD writes per byte lane under wbs_sel_i.
REQ-012 CTRL: bit0 EN, bit1 PERIODIC, bit2 IRQ_EN; other bits read 0.
REQ-013 SHALL detect a match on the first cycle count==CMP while EN=1 (rising edge of equality); count holding at CMP for N cycles yields one match.
REQ-014 On match SHALL set STATUS.PEND (bit0) and, if PERIODIC=1, load CMP with CMP+PERIOD modulo 2^BITS (wrap, no saturation).
REQ-015 STATUS.PEND SHALL clear on write of 1 to bit0 (W1C); a match in the same cycle as a clear wins (PEND stays 1).
REQ-016 A CPU write to CMP in the same cycle as a periodic reload SHALL win over the reload.
REQ-017 irq SHALL equal PEND & IRQ_EN, registered; deasserts the cycle after PEND clears or IRQ_EN drops.
REQ-018 Capture FIFO: on match, push count value; full -> drop and set STATUS.OVF (bit1, W1C, set wins over clear).
REQ-019 Read of CAPTURE SHALL return head entry and pop; empty -> return 0, no pop, no error.
REQ-020 Simultaneous push and pop when full SHALL both occur, level unchanged, no OVF.
REQ-021 STATUS[12:8] SHALL report FIFO level (0..FIFO_DEPTH); STATUS[2] SHALL be FIFO empty.

Reset
REQ-022 On wb_rst_ni=0 at a clock edge: CTRL=0, CMP=0, PERIOD=0, PEND=0, OVF=0, FIFO emptied, wbs_ack_o=0, wbs_dat_o=0, irq=0.
REQ-023 Reset mid-transaction SHALL abort it without ack; reset dominates all same-cycle events.

Configuration
REQ-024 Macro COUNT_CMP_CAPTURE_EN defined: capture FIFO and REQ-018..021 implemented.
REQ-025 Macro undefined: no FIFO storage; CAPTURE reads 0, STATUS[12:8]=0, STATUS[2]=1, OVF always 0; REQ-009..017 unchanged.

Verification
REQ-026 Reset release, read all offsets -> all 0 except STATUS=0x4; irq=0.
REQ-027 CMP=0x10, CTRL=0x5, count ramps 0..0x20 -> PEND=1 and irq=1 from count 0x10 onward; single capture 0x10; W1C 0x1 -> irq low next cycle.
REQ-028 CMP=0xFFFFFFF0, PERIOD=0x20, CTRL=0x7 -> matches at 0xFFFFFFF0, then CMP reads 0x00000010 (wrap); second match at 0x10.
REQ-029 Five matches with FIFO_DEPTH=4, no pops -> level 4, OVF=1, pops return first four values, fifth pop returns 0.
REQ-030 Count held at CMP 8 cycles -> one capture; W1C on PEND coincident with new match -> PEND stays 1.
REQ-031 Byte write sel=0x2 data 0xAABBCCDD to CMP=0 -> CMP=0x0000CC00; build without COUNT_CMP_CAPTURE_EN -> CAPTURE reads 0 after matches.

Source files
------------

// File: rtl/count_cmp_irq.sv
// count_cmp_irq: compare/capture/interrupt stage behind a Wishbone slave.
//
// Watches a free-running count from the upstream counter. The first cycle
// that count equals CMP while enabled is a match. A match sets STATUS.PEND
// and can reload CMP with CMP+PERIOD. It can also capture the count value
// into a small FIFO that the CPU drains through the CAPTURE register.
//
// Optional feature: define COUNT_CMP_CAPTURE_EN to build the capture FIFO.
// Without it, CAPTURE reads 0, the level reads 0, EMPTY reads 1 and OVF
// stays 0.
//
// Register map (wbs_adr_i[4:2]):
//   0 CTRL    bit0 EN, bit1 PERIODIC, bit2 IRQ_EN
//   1 CMP     compare value, byte-lane writes
//   2 PERIOD  reload increment, byte-lane writes
//   3 STATUS  bit0 PEND (W1C), bit1 OVF (W1C), bit2 FIFO empty, [12:8] level
//   4 CAPTURE read returns the FIFO head and pops it (0 when empty)
//   other     read 0, writes ignored, still acknowledged
//
// Ports:
//   wb_clk_i   single clock, rising edge
//   wb_rst_ni  synchronous active-low reset
//   count      upstream count value, BITS wide (BITS <= 32)
//   wbs_*      Wishbone slave request/response, one-cycle registered ack
//   irq        registered level interrupt, PEND & IRQ_EN

module count_cmp_irq #(
    parameter int unsigned BITS       = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_ni,
    input  logic [BITS-1:0] count,
    input  logic            wbs_stb_i,
    input  logic            wbs_cyc_i,
    input  logic            wbs_we_i,
    input  logic [3:0]      wbs_sel_i,
    input  logic [31:0]     wbs_adr_i,
    input  logic [31:0]     wbs_dat_i,
    output logic            wbs_ack_o,
    output logic [31:0]     wbs_dat_o,
    output logic            irq
);

    localparam logic [2:0] AdrCtrl    = 3'd0;
    localparam logic [2:0] AdrCmp     = 3'd1;
    localparam logic [2:0] AdrPeriod  = 3'd2;
    localparam logic [2:0] AdrStatus  = 3'd3;
    localparam logic [2:0] AdrCapture = 3'd4;

    // Registers
    logic [2:0]      ctrl_q, ctrl_d;
    logic [BITS-1:0] cmp_q, cmp_d;
    logic [BITS-1:0] period_q, period_d;
    logic            pend_q, pend_d;
    logic            ovf_q, ovf_d;
    logic            hit_q;
    logic            ack_q;
    logic [31:0]     rdata_q;
    logic            irq_q;

    // Bus decode
    logic        req;
    logic        wr_req;
    logic        rd_req;
    logic [2:0]  adr;
    logic [31:0] rdata;
    logic [31:0] status;
    logic        unused_adr;

    // Match detection
    logic en;
    logic periodic;
    logic irq_en;
    logic hit;
    logic match;

    // Capture FIFO view shared by both builds
    logic            fifo_empty;
    logic [4:0]      fifo_level;
    logic [BITS-1:0] fifo_head;
    logic            ovf_set;

    assign en       = ctrl_q[0];
    assign periodic = ctrl_q[1];
    assign irq_en   = ctrl_q[2];

    // A new request is taken only while no ack is outstanding, so a master that
    // holds stb through the ack cycle completes one transfer every two cycles.
    assign req    = wbs_stb_i && wbs_cyc_i && !ack_q;
    assign wr_req = req && wbs_we_i;
    assign rd_req = req && !wbs_we_i;
    assign adr    = wbs_adr_i[4:2];

    assign unused_adr = ^{wbs_adr_i[31:5], wbs_adr_i[1:0]};

    // Only the rising edge of equality counts, so a count parked on CMP
    // produces a single match.
    assign hit   = en && (count == cmp_q);
    assign match = hit && !hit_q;

    function automatic logic [31:0] lane_merge(input logic [31:0] cur,
                                               input logic [31:0] wdat,
                                               input logic [3:0]  sel);
        logic [31:0] res;
        res = cur;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) begin
                res[8*i +: 8] = wdat[8*i +: 8];
            end
        end
        return res;
    endfunction

`ifdef COUNT_CMP_CAPTURE_EN
    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned LvlW = $clog2(FIFO_DEPTH + 1);

    logic [BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0] level_q, level_d;
    logic            fifo_full;
    logic            fifo_push;
    logic            fifo_pop;

    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == LvlW'(FIFO_DEPTH));
    assign fifo_pop   = rd_req && (adr == AdrCapture) && !fifo_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign fifo_push  = match && (!fifo_full || fifo_pop);
    assign ovf_set    = match && fifo_full && !fifo_pop;
    assign fifo_head  = mem_q[rd_ptr_q];
    assign fifo_level = 5'(level_q);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        // Depth is a power of two, so the pointers wrap naturally.
        if (fifo_push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (fifo_pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        if (fifo_push && !fifo_pop) begin
            level_d = level_q + LvlW'(1);
        end else if (!fifo_push && fifo_pop) begin
            level_d = level_q - LvlW'(1);
        end
    end

    // Storage needs no reset; the level counter gates every read.
    always_ff @(posedge wb_clk_i) begin
        if (fifo_push) begin
            mem_q[wr_ptr_q] <= count;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end
`else
    assign fifo_empty = 1'b1;
    assign fifo_level = '0;
    assign fifo_head  = '0;
    assign ovf_set    = 1'b0;
`endif

    assign status = {19'd0, fifo_level, 5'd0, fifo_empty, ovf_q, pend_q};

    always_comb begin
        rdata = '0;
        case (adr)
            AdrCtrl:    rdata = {29'd0, ctrl_q};
            AdrCmp:     rdata = 32'(cmp_q);
            AdrPeriod:  rdata = 32'(period_q);
            AdrStatus:  rdata = status;
            AdrCapture: rdata = fifo_empty ? 32'd0 : 32'(fifo_head);
            default:    rdata = '0;
        endcase
    end

    always_comb begin
        ctrl_d   = ctrl_q;
        cmp_d    = cmp_q;
        period_d = period_q;
        pend_d   = pend_q;
        ovf_d    = ovf_q;

        // Periodic reload wraps modulo 2^BITS; a same-cycle CPU write overrides it.
        if (match && periodic) begin
            cmp_d = cmp_q + period_q;
        end

        if (wr_req) begin
            case (adr)
                AdrCtrl: begin
                    if (wbs_sel_i[0]) begin
                        ctrl_d = wbs_dat_i[2:0];
                    end
                end
                AdrCmp:    cmp_d    = BITS'(lane_merge(32'(cmp_q), wbs_dat_i, wbs_sel_i));
                AdrPeriod: period_d = BITS'(lane_merge(32'(period_q), wbs_dat_i, wbs_sel_i));
                AdrStatus: begin
                    if (wbs_dat_i[0]) begin
                        pend_d = 1'b0;
                    end
                    if (wbs_dat_i[1]) begin
                        ovf_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end

        // Set wins over a same-cycle W1C.
        if (match) begin
            pend_d = 1'b1;
        end
        if (ovf_set) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            ctrl_q   <= '0;
            cmp_q    <= '0;
            period_q <= '0;
            pend_q   <= 1'b0;
            ovf_q    <= 1'b0;
            hit_q    <= 1'b0;
            ack_q    <= 1'b0;
            rdata_q  <= '0;
            irq_q    <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            cmp_q    <= cmp_d;
            period_q <= period_d;
            pend_q   <= pend_d;
            ovf_q    <= ovf_d;
            hit_q    <= hit;
            ack_q    <= req;
            rdata_q  <= rd_req ? rdata : 32'd0;
            irq_q    <= pend_q && irq_en;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = rdata_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_count_cmp_irq.sv
// Bench for count_cmp_irq: directed scenarios followed by random traffic,
// checked against a register/queue-level reference model. Read data goes
// through a scoreboard queue that an ack-driven monitor drains.
module tb_count_cmp_irq;

    localparam int unsigned DEPTH = 4;
`ifdef COUNT_CMP_CAPTURE_EN
    localparam bit CAP = 1'b1;
`else
    localparam bit CAP = 1'b0;
`endif

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_ni;
    logic [31:0] count;
    logic        wbs_stb_i, wbs_cyc_i, wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i, wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        irq;

    always #5 wb_clk_i = ~wb_clk_i;

    count_cmp_irq #(.BITS(32), .FIFO_DEPTH(DEPTH)) dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_ni (wb_rst_ni),
        .count     (count),
        .wbs_stb_i (wbs_stb_i),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_sel_i (wbs_sel_i),
        .wbs_adr_i (wbs_adr_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_ack_o (wbs_ack_o),
        .wbs_dat_o (wbs_dat_o),
        .irq       (irq)
    );

    typedef struct {
        bit          rd;
        logic [31:0] exp;
        logic [2:0]  a;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model state: the architectural registers plus a plain queue.
    logic [2:0]  m_ctrl = '0;
    logic [31:0] m_cmp = '0;
    logic [31:0] m_period = '0;
    bit          m_pend = 0, m_ovf = 0, m_prev = 0, m_ack = 0, m_irq = 0, m_rst_last = 1;
    logic [31:0] m_fifo[$];

    logic [31:0] cnt = '0;
    bit          cnt_inc = 0;
    bit          cnt_rand = 0;

    function automatic logic [31:0] model_read(input logic [2:0] a);
        logic [31:0] st;
        int lvl;
        lvl = m_fifo.size();
        st = 32'd0;
        st[0] = m_pend;
        st[1] = m_ovf;
        st[2] = (lvl == 0);
        st[12:8] = lvl[4:0];
        case (a)
            3'd0: return {29'd0, m_ctrl};
            3'd1: return m_cmp;
            3'd2: return m_period;
            3'd3: return st;
            3'd4: return (lvl > 0) ? m_fifo[0] : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] apply_sel(input logic [31:0] cur, input logic [31:0] d,
                                              input logic [3:0] se);
        logic [31:0] mask;
        mask = {{8{se[3]}}, {8{se[2]}}, {8{se[1]}}, {8{se[0]}}};
        return (cur & ~mask) | (d & mask);
    endfunction

    // Advance the model across one clock edge with the inputs presented to it.
    task automatic model_step(input bit r, input bit s, input bit w, input logic [2:0] a,
                              input logic [31:0] d, input logic [3:0] se, input logic [31:0] c);
        bit          is_hit, is_match, acc, irq_n, pend_n, ovf_n;
        logic [31:0] cmp_n;
        exp_t        e;
        if (!r) begin
            m_ctrl = '0; m_cmp = '0; m_period = '0;
            m_pend = 0; m_ovf = 0; m_prev = 0; m_ack = 0; m_irq = 0;
            m_fifo.delete();
            return;
        end
        is_hit   = m_ctrl[0] && (c == m_cmp);
        is_match = is_hit && !m_prev;
        acc      = s && !m_ack;
        irq_n    = m_pend && m_ctrl[2];
        pend_n   = m_pend;
        ovf_n    = m_ovf;
        cmp_n    = m_cmp;
        if (acc) begin
            e.rd  = !w;
            e.a   = a;
            e.exp = w ? 32'd0 : model_read(a);
            sb_q.push_back(e);
        end
        if (is_match && m_ctrl[1]) cmp_n = m_cmp + m_period;
        if (acc && w) begin
            case (a)
                3'd0: if (se[0]) m_ctrl = d[2:0];
                3'd1: cmp_n = apply_sel(m_cmp, d, se);
                3'd2: m_period = apply_sel(m_period, d, se);
                3'd3: begin
                    if (d[0]) pend_n = 0;
                    if (d[1]) ovf_n = 0;
                end
                default: ;
            endcase
        end
        if (acc && !w && a == 3'd4 && m_fifo.size() > 0) void'(m_fifo.pop_front());
        if (is_match) begin
            pend_n = 1;
            if (CAP) begin
                if (m_fifo.size() < DEPTH) m_fifo.push_back(c);
                else ovf_n = 1;
            end
        end
        m_cmp  = cmp_n;
        m_pend = pend_n;
        m_ovf  = ovf_n;
        m_prev = is_hit;
        m_ack  = acc;
        m_irq  = irq_n;
    endtask

    task automatic step(input bit r, input bit s, input bit w, input logic [2:0] a,
                        input logic [31:0] d, input logic [3:0] se);
        logic [31:0] rnd;
        @(negedge wb_clk_i);
        vectors++;
        if (irq !== m_irq) begin
            miscompares++;
            $display("FAIL irq: got %0b want %0b at %0t", irq, m_irq, $time);
        end
        vectors++;
        if (wbs_ack_o !== m_ack) begin
            miscompares++;
            $display("FAIL ack: got %0b want %0b at %0t", wbs_ack_o, m_ack, $time);
        end
        if (m_rst_last) begin
            vectors++;
            if (wbs_dat_o !== 32'd0) begin
                miscompares++;
                $display("FAIL reset_dat: got %h want 00000000 at %0t", wbs_dat_o, $time);
            end
        end
        if (cnt_rand) begin
            if ($urandom_range(0, 5) == 0) cnt = $urandom_range(0, 31);
            else if ($urandom_range(0, 1) == 1) cnt = cnt + 1;
        end
        rnd       = $urandom();
        wb_rst_ni = r;
        count     = cnt;
        wbs_stb_i = s;
        wbs_cyc_i = s;
        wbs_we_i  = w;
        wbs_sel_i = se;
        wbs_dat_i = d;
        // Junk in the undecoded address bits must not matter.
        wbs_adr_i = {rnd[26:0], a, rnd[31:30]};
        m_rst_last = !r;
        model_step(r, s, w, a, d, se, cnt);
        if (cnt_inc) cnt = cnt + 1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] se);
        step(1, 1, 1, a, d, se);
        step(1, 1, 1, a, d, se);
    endtask

    task automatic rd(input logic [2:0] a);
        step(1, 1, 0, a, 32'd0, 4'hF);
        step(1, 1, 0, a, 32'd0, 4'hF);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1, 0, 0, 3'd0, 32'd0, 4'h0);
    endtask

    // Monitor: every ack pops one scoreboard entry; reads are compared.
    always begin
        @(posedge wb_clk_i);
        #1;
        if (wbs_ack_o === 1'b1) begin
            if (sb_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL stray_ack: got ack=1 want no ack at %0t", $time);
            end else begin
                mon_e = sb_q.pop_front();
                if (mon_e.rd) begin
                    vectors++;
                    if (wbs_dat_o !== mon_e.exp) begin
                        miscompares++;
                        $display("FAIL read[%0d]: got %h want %h at %0t",
                                 mon_e.a, wbs_dat_o, mon_e.exp, $time);
                    end
                end
            end
        end
    end

    initial begin
        wb_rst_ni = 1'b0;
        count     = '0;
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;
        wbs_we_i  = 1'b0;
        wbs_sel_i = '0;
        wbs_adr_i = '0;
        wbs_dat_i = '0;

        // Reset with a request pending: it must be dropped without an ack.
        step(0, 1, 1, 3'd1, 32'h1234, 4'hF);
        step(0, 1, 1, 3'd1, 32'h1234, 4'hF);
        step(0, 0, 0, 3'd0, 32'd0, 4'h0);
        for (int i = 0; i < 8; i++) rd(3'(i));

        // Byte-lane write into CMP.
        wr(3'd1, 32'hAABBCCDD, 4'b0010);
        rd(3'd1);

        // Ramp through CMP=0x10 with IRQ_EN, then clear PEND.
        wr(3'd1, 32'h10, 4'hF);
        cnt = 0;
        cnt_inc = 1;
        wr(3'd0, 32'h5, 4'hF);
        idle(40);
        cnt_inc = 0;
        rd(3'd3);
        rd(3'd4);
        rd(3'd4);
        wr(3'd3, 32'h1, 4'hF);
        idle(3);

        // Periodic reload wrapping through 2^32.
        wr(3'd0, 32'h0, 4'hF);
        cnt = 32'hFFFF_FFE0;
        cnt_inc = 1;
        wr(3'd1, 32'hFFFF_FFF0, 4'hF);
        wr(3'd2, 32'h20, 4'hF);
        wr(3'd0, 32'h7, 4'hF);
        idle(60);
        cnt_inc = 0;
        rd(3'd1);
        rd(3'd4);
        rd(3'd4);
        rd(3'd3);
        wr(3'd3, 32'h3, 4'hF);

        // Five matches with no pops: overflow, then drain.
        wr(3'd0, 32'h1, 4'hF);
        wr(3'd1, 32'h100, 4'hF);
        rd(3'd4);
        rd(3'd4);
        for (int i = 0; i < 5; i++) begin
            cnt = 32'h100; idle(3);
            cnt = 32'h0;   idle(1);
        end
        rd(3'd3);
        for (int i = 0; i < 5; i++) rd(3'd4);
        wr(3'd3, 32'h3, 4'hF);

        // Count parked on CMP, then W1C colliding with a fresh match.
        cnt = 32'h100; idle(8);
        cnt = 32'h0;   idle(2);
        wr(3'd0, 32'h5, 4'hF);
        cnt = 32'h100;
        wr(3'd3, 32'h1, 4'hF);
        cnt = 32'h0;
        rd(3'd3);
        wr(3'd3, 32'h1, 4'hF);
        idle(2);

        // Fill the FIFO, then push and pop in the same cycle while full.
        for (int i = 0; i < 2; i++) begin
            cnt = 32'h100; idle(2);
            cnt = 32'h0;   idle(1);
        end
        cnt = 32'h100;
        rd(3'd4);
        cnt = 32'h0;
        rd(3'd3);
        for (int i = 0; i < 4; i++) rd(3'd4);
        rd(3'd3);

        // Random traffic.
        cnt_rand = 1;
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 9))
                0: wr(3'd0, $urandom(), 4'($urandom_range(0, 15)));
                1: wr(3'd1, $urandom_range(0, 31), 4'($urandom_range(0, 15)));
                2: wr(3'd2, $urandom_range(0, 15), 4'hF);
                3: wr(3'd3, $urandom_range(0, 3), 4'hF);
                4, 5: rd(3'($urandom_range(0, 7)));
                6: rd(3'd4);
                7: rd(3'd3);
                8: idle($urandom_range(1, 4));
                default: begin
                    if ($urandom_range(0, 4) == 0) step(0, 1, 1, 3'd1, $urandom(), 4'hF);
                    else idle(1);
                end
            endcase
        end
        cnt_rand = 0;
        idle(4);

        vectors++;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
